// File: rtl/uart_reader_pkg.sv
// Shared constants for the debugger-side UART receive assembler: default
// bus widths, timeout default and the 2-bit FSM state encodings.
package uart_reader_pkg;

  localparam int BYTE_SIZE = 8;

  localparam int DEFAULT_UART_READER_BUS_SIZE     = BYTE_SIZE;
  localparam int DEFAULT_UART_READER_OUT_BUS_SIZE = 32;
  localparam int DEFAULT_UART_READER_TIMEOUT      = 0;

  localparam logic [1:0] UART_READER_STATE_IDLE    = 2'd0;
  localparam logic [1:0] UART_READER_STATE_RD_IDLE = 2'd1;
  localparam logic [1:0] UART_READER_STATE_RD      = 2'd2;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/uart_reader.sv
// Pops OUT_BUS_SIZE/UART_BUS_SIZE bytes from a first-word-fall-through RX FIFO and
// packs them little-endian into one word; an optional inactivity timeout aborts a stalled read.
module uart_reader
  import uart_reader_pkg::*;
#(
  parameter int UART_BUS_SIZE  = DEFAULT_UART_READER_BUS_SIZE,
  parameter int OUT_BUS_SIZE   = DEFAULT_UART_READER_OUT_BUS_SIZE,
  parameter int TIMEOUT_CYCLES = DEFAULT_UART_READER_TIMEOUT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_uart_empty,
  input  logic [UART_BUS_SIZE-1:0] i_uart_data_rd,
  input  logic                     i_start_rd,
  output logic                     o_uart_rd,
  output logic                     o_rd_end,
  output logic                     o_rd_timeout,
  output logic [OUT_BUS_SIZE-1:0]  o_rd_data
);

  localparam int N     = OUT_BUS_SIZE / UART_BUS_SIZE;
  localparam int PTR_W = $clog2(N) + 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]              state, state_next;
  logic [PTR_W-1:0]        ptr, ptr_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [OUT_BUS_SIZE-1:0] buffer, buffer_next;
  logic                    uart_rd_next;
  logic                    rd_end_next;
  logic                    rd_timeout_next;
  logic [OUT_BUS_SIZE-1:0] rd_data_next;

  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    cnt_next        = cnt;
    buffer_next     = buffer;
    uart_rd_next    = LOW;
    rd_end_next     = o_rd_end;
    rd_timeout_next = o_rd_timeout;
    rd_data_next    = o_rd_data;

    case (state)
      UART_READER_STATE_IDLE: begin
        if (i_start_rd) begin
          rd_end_next     = LOW;
          rd_timeout_next = LOW;
          cnt_next        = '0;
          state_next      = UART_READER_STATE_RD_IDLE;
        end
      end

      UART_READER_STATE_RD_IDLE: begin
        if (ptr == PTR_FULL) begin
          rd_data_next = buffer;
          rd_end_next  = HIGH;
          ptr_next     = '0;
          state_next   = UART_READER_STATE_IDLE;
        end else if (!i_uart_empty) begin
          // Capture and pop in the same cycle so the stored byte is the one removed.
          for (int i = 0; i < N; i++) begin
            if (ptr == PTR_W'(i)) begin
              buffer_next[i*UART_BUS_SIZE +: UART_BUS_SIZE] = i_uart_data_rd;
            end
          end
          uart_rd_next = HIGH;
          cnt_next     = '0;
          state_next   = UART_READER_STATE_RD;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          rd_timeout_next = HIGH;
          ptr_next        = '0;
          state_next      = UART_READER_STATE_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      UART_READER_STATE_RD: begin
        uart_rd_next = LOW;
        ptr_next     = ptr + 1'b1;
        state_next   = UART_READER_STATE_RD_IDLE;
      end

      default: begin
        state_next = UART_READER_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= UART_READER_STATE_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      buffer       <= '0;
      o_uart_rd    <= LOW;
      o_rd_end     <= LOW;
      o_rd_timeout <= LOW;
      o_rd_data    <= '0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      cnt          <= cnt_next;
      buffer       <= buffer_next;
      o_uart_rd    <= uart_rd_next;
      o_rd_end     <= rd_end_next;
      o_rd_timeout <= rd_timeout_next;
      o_rd_data    <= rd_data_next;
    end
  end

endmodule

// File: tb/tb_uart_reader.sv
// Bench for uart_reader: two instances (timeout disabled / 16 cycles) share one
// modelled RX FIFO; results are checked against a byte-packing and latency model.
module tb_uart_reader;

  localparam int N       = 4;
  localparam int TMO     = 16;
  localparam int FIFO_SZ = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [1:0] start = 2'b00;

  logic        uart_empty;
  logic [7:0]  uart_data;
  logic [1:0]  uart_rd;
  logic [1:0]  rd_end;
  logic [1:0]  rd_tmo;
  logic [31:0] rd_data [2];

  uart_reader #(.UART_BUS_SIZE(8), .OUT_BUS_SIZE(32), .TIMEOUT_CYCLES(0)) u_dut0 (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_uart_empty   (uart_empty),
    .i_uart_data_rd (uart_data),
    .i_start_rd     (start[0]),
    .o_uart_rd      (uart_rd[0]),
    .o_rd_end       (rd_end[0]),
    .o_rd_timeout   (rd_tmo[0]),
    .o_rd_data      (rd_data[0])
  );

  uart_reader #(.UART_BUS_SIZE(8), .OUT_BUS_SIZE(32), .TIMEOUT_CYCLES(TMO)) u_dut1 (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_uart_empty   (uart_empty),
    .i_uart_data_rd (uart_data),
    .i_start_rd     (start[1]),
    .o_uart_rd      (uart_rd[1]),
    .o_rd_end       (rd_end[1]),
    .o_rd_timeout   (rd_tmo[1]),
    .o_rd_data      (rd_data[1])
  );

  // ---------------- RX FIFO model ----------------
  logic [7:0] fifo_mem [FIFO_SZ];
  int         wr_ptr      = 0;
  int         rd_ptr      = 0;
  int         pop_total   = 0;
  int         pop_base    = 0;
  int         stall_at    = 0;
  int         stall_len   = 0;
  int         stall_left  = 0;
  int         double_pops = 0;
  logic       flush       = 1'b0;
  logic [1:0] prev_rd     = 2'b00;

  assign uart_empty = (rd_ptr == wr_ptr) || (stall_left != 0);
  assign uart_data  = fifo_mem[rd_ptr % FIFO_SZ];

  always @(posedge clk) begin
    prev_rd <= uart_rd;
    if ((uart_rd & prev_rd) != 2'b00) double_pops <= double_pops + 1;
    if (flush) begin
      rd_ptr     <= wr_ptr;
      stall_left <= 0;
    end else if (uart_rd != 2'b00) begin
      rd_ptr    <= rd_ptr + 1;
      pop_total <= pop_total + 1;
      if (pop_total + 1 - pop_base == stall_at) stall_left <= stall_len;
    end else if (stall_left != 0) begin
      stall_left <= stall_left - 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_data [2];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b [4]);
    logic [31:0] w = 0;
    for (int i = 0; i < N; i++) w = w + (32'(b[i]) << (8 * i));
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % FIFO_SZ] = b;
    wr_ptr++;
  endtask

  // Pulse start on instance d (called at a negedge); returns the number of edges
  // after the start-sampling edge at which a posedge consumer first sees end/timeout.
  task automatic do_read(input int d, input int max_edges, output int edges,
                         output logic got_end, output logic got_tmo);
    pop_base = pop_total;
    start[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    check($sformatf("flags_clear_on_start_dut%0d", d), {30'b0, rd_end[d], rd_tmo[d]}, 32'd0);
    edges   = 0;
    got_end = 1'b0;
    got_tmo = 1'b0;
    while (edges < max_edges) begin
      got_end = rd_end[d];
      got_tmo = rd_tmo[d];
      @(posedge clk);
      edges++;
      if (got_end || got_tmo) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic read_word(input string tag, input int d, input logic [7:0] b [4],
                           input int s_at, input int s_len);
    int   edges;
    logic got_end, got_tmo;
    for (int i = 0; i < N; i++) push(b[i]);
    stall_at  = s_at;
    stall_len = s_len;
    exp_q.push_back(pack(b));
    do_read(d, 100, edges, got_end, got_tmo);
    exp_data[d] = exp_q.pop_front();
    check({tag, "_end"},     32'(got_end), 32'd1);
    check({tag, "_tmo"},     32'(got_tmo), 32'd0);
    check({tag, "_latency"}, 32'(edges), 32'(2 * N + 2 + s_len));
    check({tag, "_data"},    rd_data[d], exp_data[d]);
    check({tag, "_pops"},    32'(pop_total - pop_base), 32'(N));
    stall_at = 0;
  endtask

  task automatic read_partial(input string tag, input int k);
    int   edges;
    logic got_end, got_tmo;
    for (int i = 0; i < k; i++) push(8'($urandom_range(0, 255)));
    stall_at = 0;
    do_read(1, 100, edges, got_end, got_tmo);
    check({tag, "_tmo"},     32'(got_tmo), 32'd1);
    check({tag, "_end"},     32'(got_end), 32'd0);
    check({tag, "_latency"}, 32'(edges), 32'(2 * k + TMO + 1));
    check({tag, "_data"},    rd_data[1], exp_data[1]);
    check({tag, "_pops"},    32'(pop_total - pop_base), 32'(k));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] bt [4];
  int         seen;

  initial begin
    exp_data[0] = 32'd0;
    exp_data[1] = 32'd0;

    // 1: reset held 3 cycles with a byte waiting in the FIFO
    push(8'hAA);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_uart_rd",  {30'b0, uart_rd}, 32'd0);
    check("reset_rd_end",   {30'b0, rd_end}, 32'd0);
    check("reset_rd_tmo",   {30'b0, rd_tmo}, 32'd0);
    check("reset_data0",    rd_data[0], 32'd0);
    check("reset_data1",    rd_data[1], 32'd0);
    check("reset_no_pop",   32'(pop_total), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_pop",    32'(pop_total), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // 2: basic four-byte read
    bt = '{8'h78, 8'h56, 8'h34, 8'h12};
    read_word("basic", 0, bt, 0, 0);
    check("basic_word_literal", rd_data[0], 32'h12345678);

    // 3: FIFO empty for 5 cycles before the 3rd byte
    bt = '{8'h11, 8'h22, 8'h33, 8'h44};
    read_word("stall5", 0, bt, 2, 5);

    // 4: timeout instance: full word, then only 2 bytes, then recovery
    bt = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    read_word("tmo_prev", 1, bt, 0, 0);
    read_partial("tmo_two_bytes", 2);
    bt = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    read_word("tmo_recover", 1, bt, 0, 0);

    // 5: reset after the 2nd pop of a read
    for (int i = 0; i < N; i++) push(8'(8'hE0 + i));
    pop_base = pop_total;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    seen = 0;
    while ((pop_total - pop_base) < 2 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("midreset_two_pops", 32'(pop_total - pop_base), 32'd2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_data[0] = 32'd0;
    exp_data[1] = 32'd0;
    check("midreset_uart_rd", {30'b0, uart_rd}, 32'd0);
    check("midreset_rd_end",  {30'b0, rd_end}, 32'd0);
    check("midreset_data0",   rd_data[0], exp_data[0]);
    check("midreset_data1",   rd_data[1], exp_data[1]);
    reset = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bt = '{8'h9A, 8'hBC, 8'hDE, 8'hF1};
    read_word("after_reset", 0, bt, 0, 0);

    // 6: start held high across completion, back-to-back words
    bt = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < N; i++) push(bt[i]);
    bt = '{8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < N; i++) push(bt[i]);
    pop_base = pop_total;
    start[0] = 1'b1;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!rd_end[0] && seen < 40);
    check("b2b_first_end",  32'(rd_end[0]), 32'd1);
    check("b2b_first_data", rd_data[0], 32'hDEADBEEF);
    @(negedge clk);
    check("b2b_end_clears", 32'(rd_end[0]), 32'd0);
    start[0] = 1'b0;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!rd_end[0] && seen < 40);
    check("b2b_second_end",  32'(rd_end[0]), 32'd1);
    check("b2b_second_data", rd_data[0], 32'h01020304);
    check("b2b_pops",        32'(pop_total - pop_base), 32'd8);
    exp_data[0] = 32'h01020304;
    @(negedge clk);

    // 7: randomized reads on both instances
    for (int it = 0; it < 14; it++) begin
      int d;
      int k;
      for (int i = 0; i < N; i++) bt[i] = 8'($urandom_range(0, 255));
      d = int'($urandom_range(0, 1));
      if (d == 0) begin
        read_word($sformatf("rnd%0d_d0", it), 0, bt,
                  int'($urandom_range(1, 3)), int'($urandom_range(0, 7)));
      end else begin
        k = int'($urandom_range(0, 4));
        if (k == N)
          read_word($sformatf("rnd%0d_d1", it), 1, bt,
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 10)));
        else
          read_partial($sformatf("rnd%0d_tmo", it), k);
      end
    end

    check("single_cycle_pops", 32'(double_pops), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
